// File: rtl/wdt_pkg.sv
// Shared state type, default widths and the effective-timeout helper for the
// multi-channel watchdog.
package wdt_pkg;

    localparam int unsigned WDT_CNT_W     = 32;
    // Widest counter the eff_timeout helper can carry; channels cast in and out.
    localparam int unsigned WDT_MAX_CNT_W = 64;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        EXPIRED  = 2'd2
    } wdt_state_e;

    // A programmed timeout of zero behaves as a one-cycle timeout.
    function automatic logic [WDT_MAX_CNT_W-1:0] eff_timeout(
        input logic [WDT_MAX_CNT_W-1:0] timeout
    );
        return (timeout == '0) ? WDT_MAX_CNT_W'(1) : timeout;
    endfunction

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: pet edge detect, counter, DISABLED/RUN/EXPIRED FSM and
// sticky flags. Early-pet window checking only exists with WDT_MULTI_WINDOW_EN.
module wdt_channel
    import wdt_pkg::*;
#(
    parameter int unsigned CNT_W = WDT_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable_i,
    input  logic             pet_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic [CNT_W-1:0] window_i,
    input  logic             irq_clr_i,
    output logic             irq_o,
    output logic             early_pet_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wdt_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pet_q;
    logic             irq_q;
    logic             early_q;

    logic [CNT_W-1:0] eff_to;
    logic             pet_redge;
    logic             at_terminal;
    logic             pet_early;

    assign pet_redge   = pet_i & ~pet_q;
    assign eff_to      = CNT_W'(eff_timeout(WDT_MAX_CNT_W'(timeout_i)));
    assign at_terminal = (cnt_q == (eff_to - CNT_ONE));

`ifdef WDT_MULTI_WINDOW_EN
    localparam bit WINDOW_EN = 1'b1;
    assign pet_early = pet_redge & (cnt_q < window_i);
`else
    localparam bit WINDOW_EN = 1'b0;
    logic unused_window;
    assign unused_window = ^window_i;
    assign pet_early     = 1'b0;
`endif

    // Flags clear first so that a violation on the same edge overrides the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DISABLED;
            cnt_q   <= '0;
            pet_q   <= 1'b0;
            irq_q   <= 1'b0;
            early_q <= 1'b0;
        end else begin
            pet_q <= pet_i;
            if (irq_clr_i) begin
                irq_q   <= 1'b0;
                early_q <= 1'b0;
            end
            unique case (state_q)
                DISABLED: begin
                    cnt_q <= '0;
                    if (enable_i) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!enable_i) begin
                        state_q <= DISABLED;
                        cnt_q   <= '0;
                    end else if (pet_early) begin
                        state_q <= EXPIRED;
                        irq_q   <= 1'b1;
                        early_q <= 1'b1;
                    end else if (pet_redge) begin
                        cnt_q <= '0;
                    end else if (at_terminal) begin
                        state_q <= EXPIRED;
                        irq_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                EXPIRED: begin
                    if (irq_clr_i) begin
                        cnt_q   <= '0;
                        state_q <= enable_i ? RUN : DISABLED;
                    end else if (!enable_i) begin
                        cnt_q   <= '0;
                        state_q <= DISABLED;
                    end
                end
                default: begin
                    state_q <= DISABLED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign irq_o       = irq_q;
    assign early_pet_o = WINDOW_EN & early_q;

endmodule

// File: rtl/wdt_multi.sv
// Multi-channel watchdog top: NUM_CH independent wdt_channel instances plus a
// registered combined interrupt. Optional early-pet window: WDT_MULTI_WINDOW_EN.
module wdt_multi
    import wdt_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = WDT_CNT_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       pet,
    input  logic [NUM_CH*CNT_W-1:0] timeout_cnt,
    input  logic [NUM_CH*CNT_W-1:0] window_cnt,
    input  logic [NUM_CH-1:0]       irq_clr,
    output logic [NUM_CH-1:0]       irq,
    output logic [NUM_CH-1:0]       early_pet,
    output logic                    irq_any
);

    logic irq_any_d;
    logic irq_any_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        wdt_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .clk        (clk),
            .resetn     (resetn),
            .enable_i   (enable[i]),
            .pet_i      (pet[i]),
            .timeout_i  (timeout_cnt[i*CNT_W +: CNT_W]),
            .window_i   (window_cnt[i*CNT_W +: CNT_W]),
            .irq_clr_i  (irq_clr[i]),
            .irq_o      (irq[i]),
            .early_pet_o(early_pet[i])
        );
    end

    // Built from the channel flag registers, so it trails irq by one cycle.
    assign irq_any_d = |irq;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_any_q <= 1'b0;
        end else begin
            irq_any_q <= irq_any_d;
        end
    end

    assign irq_any = irq_any_q;

endmodule
